// File: rtl/pb_pkg.sv
// Shared protobuf wire-format types for the varint receive path.
// Holds the varint length limit, decoder state encoding and word type.
package pb_pkg;

    localparam int MAX_VARINT_BYTES = 10;

    typedef enum logic {
        ACCUM,
        DONE
    } varint_state_t;

    typedef logic [63:0] pb_word_t;

endpackage

// File: rtl/unzigzag.sv
// Combinational zigzag decode with optional 32-bit truncation.
// With en low the value passes through, still truncated for 32-bit fields.
module unzigzag
    import pb_pkg::*;
(
    input  pb_word_t in_val,
    input  logic     is_32,
    input  logic     en,
    output pb_word_t out_val
);

    logic [31:0] lo;

    assign lo = in_val[31:0];

    always_comb begin
        out_val = '0;
        if (is_32) begin
            if (en) begin
                out_val[31:0] = (lo >> 1) ^ {32{lo[0]}};
            end else begin
                out_val[31:0] = lo;
            end
        end else begin
            if (en) begin
                out_val = (in_val >> 1) ^ {64{in_val[0]}};
            end else begin
                out_val = in_val;
            end
        end
    end

endmodule

// File: rtl/varint_unzigzag_decoder.sv
// Byte-serial protobuf varint decoder with optional zigzag decode.
// Define VARINT_LEN_EN to expose the consumed byte count on out_len.
module varint_unzigzag_decoder
    import pb_pkg::*;
#(
    parameter int MAX_BYTES = MAX_VARINT_BYTES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_byte,
    input  logic       zz_en,
    input  logic       is_32,
    output logic       out_valid,
    input  logic       out_ready,
    output pb_word_t   out_val,
    output logic       out_err
`ifdef VARINT_LEN_EN
    ,
    output logic [3:0] out_len
`endif
);

    varint_state_t state;
    pb_word_t      acc;
    logic [3:0]    idx;
    logic          zz_q;
    logic          is32_q;

    logic          take;
    logic          first;
    logic          zz_cur;
    logic          is32_cur;
    logic [6:0]    shamt;
    pb_word_t      shifted;
    pb_word_t      acc_next;
    logic          last;
    logic          overlong;
    pb_word_t      dec_val;

    assign take  = in_valid && in_ready;
    assign first = (idx == 4'd0);

    // Field flags are taken live on the first byte, latched afterwards.
    assign zz_cur   = first ? zz_en : zz_q;
    assign is32_cur = first ? is_32 : is32_q;

    // Payload bits shifted past bit 63 fall off, so byte 10 adds only bit 0.
    assign shamt    = 7'(idx) * 7'd7;
    assign shifted  = {57'd0, in_byte[6:0]} << shamt;
    assign acc_next = acc | shifted;

    assign last     = !in_byte[7];
    assign overlong = in_byte[7] && (idx == 4'(MAX_BYTES - 1));

    unzigzag u_unzigzag (
        .in_val  (acc_next),
        .is_32   (is32_cur),
        .en      (zz_cur),
        .out_val (dec_val)
    );

`ifdef VARINT_LEN_EN
    logic [3:0] len_q;
    assign out_len = len_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            idx       <= '0;
            zz_q      <= 1'b0;
            is32_q    <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_val   <= '0;
            out_err   <= 1'b0;
`ifdef VARINT_LEN_EN
            len_q     <= '0;
`endif
        end else begin
            unique case (state)
                ACCUM: begin
                    if (take) begin
                        acc <= acc_next;
                        if (first) begin
                            zz_q   <= zz_en;
                            is32_q <= is_32;
                        end
                        if (last || overlong) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_val   <= overlong ? '0 : dec_val;
                            out_err   <= overlong;
`ifdef VARINT_LEN_EN
                            len_q     <= idx + 4'd1;
`endif
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= ACCUM;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        acc       <= '0;
                        idx       <= '0;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_varint_unzigzag_decoder.sv
// Directed bench for varint_unzigzag_decoder.
// out_len checks are active only when VARINT_LEN_EN is defined.
module tb_varint_unzigzag_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_byte;
    logic        zz_en;
    logic        is_32;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_val;
    logic        out_err;
`ifdef VARINT_LEN_EN
    logic [3:0]  out_len;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    varint_unzigzag_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_byte   (in_byte),
        .zz_en     (zz_en),
        .is_32     (is_32),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_val   (out_val),
        .out_err   (out_err)
`ifdef VARINT_LEN_EN
        ,
        .out_len   (out_len)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feeds n bytes (byte 0 in bits 7:0); zz/is32 may differ after byte 0.
    task automatic feed(input logic [79:0] b, input int n,
                        input logic zz0, input logic w0,
                        input logic zz1, input logic w1,
                        input string name);
        for (int i = 0; i < n; i++) begin
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s accept byte %0d: in_ready=%b out_valid=%b need 1/0",
                         name, i, in_ready, out_valid);
            end
            in_valid = 1'b1;
            in_byte  = b[8*i +: 8];
            zz_en    = (i == 0) ? zz0 : zz1;
            is_32    = (i == 0) ? w0 : w1;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic expect_result(input logic [63:0] val, input logic err,
                                 input logic [3:0] len, input string name);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s handshake: out_valid=%b in_ready=%b need 1/0",
                     name, out_valid, in_ready);
        end
        checks++;
        if (out_val !== val || out_err !== err) begin
            errors++;
            $display("FAIL %s value: got %h err=%b need %h err=%b",
                     name, out_val, out_err, val, err);
        end
`ifdef VARINT_LEN_EN
        checks++;
        if (out_len !== len) begin
            errors++;
            $display("FAIL %s len: got %0d need %0d", name, out_len, len);
        end
`else
        if (len == 4'hF) $display("unused len");
`endif
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s drain: out_valid=%b in_ready=%b need 0/1",
                     name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_byte = 8'h00;
        zz_en = 1'b0;
        is_32 = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
            out_val !== 64'd0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: rdy=%b vld=%b val=%h err=%b need 1/0/0/0",
                     in_ready, out_valid, out_val, out_err);
        end
`ifdef VARINT_LEN_EN
        checks++;
        if (out_len !== 4'd0) begin
            errors++;
            $display("FAIL reset len: got %0d need 0", out_len);
        end
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        feed(80'h0196, 2, 1'b0, 1'b0, 1'b0, 1'b0, "u150");
        expect_result(64'd150, 1'b0, 4'd2, "u150");
        drain("u150");
        feed(80'h00, 1, 1'b0, 1'b0, 1'b0, 1'b0, "zero");
        expect_result(64'd0, 1'b0, 4'd1, "zero");
        drain("zero");
    endtask

    task automatic test_zigzag();
        feed(80'h03, 1, 1'b1, 1'b0, 1'b1, 1'b0, "zz_m2");
        expect_result(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 4'd1, "zz_m2");
        drain("zz_m2");
        feed(80'h04, 1, 1'b1, 1'b0, 1'b1, 1'b0, "zz_p2");
        expect_result(64'd2, 1'b0, 4'd1, "zz_p2");
        drain("zz_p2");
        feed(80'h03, 1, 1'b1, 1'b1, 1'b1, 1'b1, "zz32_m2");
        expect_result(64'h0000_0000_FFFF_FFFE, 1'b0, 4'd1, "zz32_m2");
        drain("zz32_m2");
    endtask

    task automatic test_latch();
        // Flags flip after byte 0; decode must use byte-0 flags (zz64).
        feed(80'h0181, 2, 1'b1, 1'b0, 1'b0, 1'b1, "latch");
        expect_result(64'hFFFF_FFFF_FFFF_FFBF, 1'b0, 4'd2, "latch");
        drain("latch");
    endtask

    task automatic test_ten_bytes();
        feed(80'h01_FFFFFFFFFFFFFFFFFF, 10, 1'b0, 1'b1, 1'b0, 1'b1, "neg32");
        expect_result(64'h0000_0000_FFFF_FFFF, 1'b0, 4'd10, "neg32");
        drain("neg32");
        feed(80'h01_FFFFFFFFFFFFFFFFFF, 10, 1'b0, 1'b0, 1'b0, 1'b0, "max64");
        expect_result(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'd10, "max64");
        drain("max64");
    endtask

    task automatic test_overlong();
        feed({80{1'b1}}, 10, 1'b0, 1'b0, 1'b0, 1'b0, "overlong");
        expect_result(64'd0, 1'b1, 4'd10, "overlong");
        in_valid = 1'b1;
        in_byte = 8'h05;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (in_ready !== 1'b0 || out_err !== 1'b1) begin
                errors++;
                $display("FAIL overlong hold %0d: in_ready=%b err=%b need 0/1",
                         i, in_ready, out_err);
            end
        end
        in_valid = 1'b0;
        drain("overlong");
    endtask

    task automatic test_back_to_back();
        feed(80'h05, 1, 1'b0, 1'b0, 1'b0, 1'b0, "bp");
        expect_result(64'd5, 1'b0, 4'd1, "bp");
        in_valid = 1'b1;
        in_byte = 8'h07;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                out_val !== 64'd5) begin
                errors++;
                $display("FAIL bp hold %0d: vld=%b rdy=%b val=%h need 1/0/5",
                         i, out_valid, in_ready, out_val);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp release: rdy=%b vld=%b need 1/0",
                     in_ready, out_valid);
        end
        tick();
        in_valid = 1'b0;
        expect_result(64'd7, 1'b0, 4'd1, "bp_next");
        drain("bp_next");
    endtask

    task automatic test_mid_reset();
        feed(80'hFFFFFF, 3, 1'b0, 1'b0, 1'b0, 1'b0, "midrst");
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_val !== 64'd0 ||
            out_err !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst async: vld=%b val=%h err=%b rdy=%b need 0/0/0/1",
                     out_valid, out_val, out_err, in_ready);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst no_out: vld=%b need 0", out_valid);
        end
        feed(80'h01, 1, 1'b0, 1'b0, 1'b0, 1'b0, "midrst_new");
        expect_result(64'd1, 1'b0, 4'd1, "midrst_new");
        drain("midrst_new");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zigzag();
        test_latch();
        test_ten_bytes();
        test_overlong();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
